// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Fetch/execute sequencer. It holds the IR, the execute step and
//             the status flags, and selects the control word for the datapath.
//  Revision : 1.0
// ============================================================================
module control_sequencer #(
    parameter int CW_WIDTH  = 33,
    parameter int MAX_STEPS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mem_ready,
    input  logic [31:0]         instruction_in,
    input  logic [CW_WIDTH-1:0] execute_controlword,
    input  logic [4:0]          alu_status,
    input  logic                stall,
    output logic [31:0]         instruction,
    output logic [1:0]          state,
    output logic [4:0]          status,
    output logic [CW_WIDTH-1:0] controlword,
    output logic                mem_request,
    output logic                fault
);

    // Control word bit positions
    localparam int c_BIT_RF_WRITE    = 9;
    localparam int c_BIT_RAM_BUS_EN  = 8;
    localparam int c_BIT_RAM_WRITE   = 7;
    localparam int c_BIT_PC_BUS_EN   = 6;
    localparam int c_BIT_PC_FS_HI    = 5;
    localparam int c_BIT_PC_FS_LO    = 4;
    localparam int c_BIT_STATUS_LOAD = 2;

    localparam int                c_CNT_W   = $clog2(MAX_STEPS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_STEPS);

    typedef enum logic [0:0] {
        PH_FETCH   = 1'b0,
        PH_EXECUTE = 1'b1
    } phase_t;

    phase_t              r_phase;
    logic [31:0]         r_ir;
    logic [1:0]          r_state;
    logic [4:0]          r_status;
    logic [c_CNT_W-1:0]  r_step_cnt;
    logic                r_fault;

    logic [CW_WIDTH-1:0] w_fetch_cw;
    logic [CW_WIDTH-1:0] w_sel_cw;
    logic [CW_WIDTH-1:0] w_out_cw;
    logic [1:0]          w_next_state;
    logic                w_status_load;
    logic                w_step_limit;

    assign w_next_state  = execute_controlword[1:0];
    assign w_status_load = execute_controlword[c_BIT_STATUS_LOAD];
    assign w_step_limit  = (r_step_cnt >= c_CNT_MAX);

    // PC+4 is requested only in the cycle the instruction word is accepted
    always_comb begin
        w_fetch_cw                   = '0;
        w_fetch_cw[c_BIT_PC_BUS_EN]  = 1'b1;
        w_fetch_cw[c_BIT_RAM_BUS_EN] = 1'b1;
        w_fetch_cw[c_BIT_PC_FS_LO]   = mem_ready;
    end

    assign w_sel_cw = (r_phase == PH_EXECUTE) ? execute_controlword : w_fetch_cw;

    // A stalled cycle must not change architectural state anywhere downstream
    always_comb begin
        w_out_cw = w_sel_cw;
        if (stall) begin
            w_out_cw[c_BIT_RF_WRITE]    = 1'b0;
            w_out_cw[c_BIT_RAM_WRITE]   = 1'b0;
            w_out_cw[c_BIT_STATUS_LOAD] = 1'b0;
            w_out_cw[c_BIT_PC_FS_HI]    = 1'b0;
            w_out_cw[c_BIT_PC_FS_LO]    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_phase    <= PH_FETCH;
            r_ir       <= '0;
            r_state    <= 2'b00;
            r_status   <= '0;
            r_step_cnt <= '0;
            r_fault    <= 1'b0;
        end else if (!stall) begin
            case (r_phase)
                PH_FETCH: begin
                    if (mem_ready) begin
                        r_ir       <= instruction_in;
                        r_state    <= 2'b00;
                        r_step_cnt <= c_CNT_ONE;
                        r_phase    <= PH_EXECUTE;
                    end
                end
                PH_EXECUTE: begin
                    if (w_status_load) begin
                        r_status <= alu_status;
                    end
                    if (w_next_state == 2'b00) begin
                        r_phase <= PH_FETCH;
                        r_state <= 2'b00;
                    end else if (w_step_limit) begin
                        // Runaway microprogram: abandon the instruction
                        r_fault <= 1'b1;
                        r_phase <= PH_FETCH;
                        r_state <= 2'b00;
                    end else begin
                        r_state    <= w_next_state;
                        r_step_cnt <= r_step_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_phase <= PH_FETCH;
                end
            endcase
        end
    end

    assign instruction = r_ir;
    assign state       = r_state;
    assign status      = r_status;
    assign controlword = w_out_cw;
    assign mem_request = (r_phase == PH_FETCH);
    assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_sequencer
//  Purpose  : Directed scoreboard bench for control_sequencer.
//  Revision : 1.0
// ============================================================================
module tb_control_sequencer;

    localparam int SEL_INSTR = 0;
    localparam int SEL_STATE = 1;
    localparam int SEL_STAT  = 2;
    localparam int SEL_CW    = 3;
    localparam int SEL_MREQ  = 4;
    localparam int SEL_FAULT = 5;

    localparam logic [32:0] CW_FETCH      = 33'h0_0000_0140;
    localparam logic [32:0] CW_FETCH_RDY  = 33'h0_0000_0150;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_ready;
    logic [31:0] instruction_in;
    logic [32:0] execute_controlword;
    logic [4:0]  alu_status;
    logic        stall;
    logic [31:0] instruction;
    logic [1:0]  state;
    logic [4:0]  status;
    logic [32:0] controlword;
    logic        mem_request;
    logic        fault;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    control_sequencer #(
        .CW_WIDTH  (33),
        .MAX_STEPS (4)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .mem_ready           (mem_ready),
        .instruction_in      (instruction_in),
        .execute_controlword (execute_controlword),
        .alu_status          (alu_status),
        .stall               (stall),
        .instruction         (instruction),
        .state               (state),
        .status              (status),
        .controlword         (controlword),
        .mem_request         (mem_request),
        .fault               (fault)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            SEL_INSTR: return 64'(instruction);
            SEL_STATE: return 64'(state);
            SEL_STAT:  return 64'(status);
            SEL_CW:    return 64'(controlword);
            SEL_MREQ:  return 64'(mem_request);
            default:   return 64'(fault);
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [63:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_cmp++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] iw);
        mem_ready      = 1'b1;
        instruction_in = iw;
        step();
        mem_ready      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b0;
        mem_ready           = 1'b0;
        instruction_in      = '0;
        execute_controlword = '0;
        alu_status          = '0;
        stall               = 1'b0;
        step();
        step();

        // Reset state
        expect_v("rst_instr", SEL_INSTR, 64'h0);
        expect_v("rst_state", SEL_STATE, 64'h0);
        expect_v("rst_status", SEL_STAT, 64'h0);
        expect_v("rst_fault", SEL_FAULT, 64'h0);
        expect_v("rst_mreq", SEL_MREQ, 64'h1);
        expect_v("rst_cw", SEL_CW, 64'(CW_FETCH));
        check_now();

        // Idle fetch while memory is not ready
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_v("idle_mreq", SEL_MREQ, 64'h1);
            expect_v("idle_cw", SEL_CW, 64'(CW_FETCH));
            expect_v("idle_state", SEL_STATE, 64'h0);
            check_now();
        end

        // Accept instruction: PC+4 requested in the accepting cycle
        mem_ready      = 1'b1;
        instruction_in = 32'h1400_0010;
        expect_v("fetch_rdy_cw", SEL_CW, 64'(CW_FETCH_RDY));
        check_now();
        step();
        mem_ready           = 1'b0;
        execute_controlword = 33'h1_2345_6784;
        alu_status          = 5'b10101;
        expect_v("ex_instr", SEL_INSTR, 64'h1400_0010);
        expect_v("ex_state", SEL_STATE, 64'h0);
        expect_v("ex_cw", SEL_CW, 64'h1_2345_6784);
        expect_v("ex_mreq", SEL_MREQ, 64'h0);
        check_now();
        step();
        expect_v("ld_status", SEL_STAT, 64'h15);
        expect_v("ld_mreq", SEL_MREQ, 64'h1);
        expect_v("ld_state", SEL_STATE, 64'h0);
        expect_v("ld_cw", SEL_CW, 64'(CW_FETCH));
        check_now();

        // Step chain 0 -> 1 -> 2 -> fetch
        fetch(32'hA5A5_0001);
        execute_controlword = 33'h0_0000_0001;
        expect_v("chain_s0", SEL_STATE, 64'h0);
        expect_v("chain_instr", SEL_INSTR, 64'hA5A5_0001);
        check_now();
        step();
        execute_controlword = 33'h0_0000_0002;
        expect_v("chain_s1", SEL_STATE, 64'h1);
        check_now();
        step();
        execute_controlword = 33'h0_0000_0000;
        expect_v("chain_s2", SEL_STATE, 64'h2);
        expect_v("chain_cw0", SEL_CW, 64'h0);
        check_now();
        step();
        expect_v("chain_end_mreq", SEL_MREQ, 64'h1);
        expect_v("chain_end_state", SEL_STATE, 64'h0);
        expect_v("chain_status_hold", SEL_STAT, 64'h15);
        expect_v("chain_fault", SEL_FAULT, 64'h0);
        check_now();

        // Runaway microprogram trips the step limit after four execute cycles
        fetch(32'h0000_00FF);
        execute_controlword = 33'h0_0000_0001;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_v("lim_fault_low", SEL_FAULT, 64'h0);
            expect_v("lim_mreq_low", SEL_MREQ, 64'h0);
            check_now();
        end
        step();
        expect_v("lim_fault", SEL_FAULT, 64'h1);
        expect_v("lim_mreq", SEL_MREQ, 64'h1);
        expect_v("lim_state", SEL_STATE, 64'h0);
        check_now();

        // Stall during execute masks writes and freezes state
        fetch(32'h0BAD_F00D);
        execute_controlword = 33'h1_FFFF_FFFD;
        alu_status          = 5'b00011;
        stall               = 1'b1;
        expect_v("stall_cw", SEL_CW, 64'h1_FFFF_FD49);
        expect_v("stall_state", SEL_STATE, 64'h0);
        check_now();
        step();
        step();
        expect_v("stall_hold_state", SEL_STATE, 64'h0);
        expect_v("stall_hold_status", SEL_STAT, 64'h15);
        expect_v("stall_hold_mreq", SEL_MREQ, 64'h0);
        expect_v("stall_hold_instr", SEL_INSTR, 64'h0BAD_F00D);
        check_now();
        stall = 1'b0;
        expect_v("unstall_cw", SEL_CW, 64'h1_FFFF_FFFD);
        check_now();
        step();
        expect_v("unstall_state", SEL_STATE, 64'h1);
        expect_v("unstall_status", SEL_STAT, 64'h03);
        check_now();
        execute_controlword = 33'h0_0000_0200;
        step();
        expect_v("unstall_done", SEL_MREQ, 64'h1);
        expect_v("fault_sticky", SEL_FAULT, 64'h1);
        check_now();

        // Stall during fetch ignores mem_ready
        stall          = 1'b1;
        mem_ready      = 1'b1;
        instruction_in = 32'hDEAD_BEEF;
        expect_v("fstall_cw", SEL_CW, 64'(CW_FETCH));
        check_now();
        step();
        expect_v("fstall_instr", SEL_INSTR, 64'h0BAD_F00D);
        expect_v("fstall_mreq", SEL_MREQ, 64'h1);
        check_now();
        stall = 1'b0;
        expect_v("fretry_cw", SEL_CW, 64'(CW_FETCH_RDY));
        check_now();
        step();
        mem_ready = 1'b0;
        expect_v("fretry_instr", SEL_INSTR, 64'hDEAD_BEEF);
        expect_v("fretry_mreq", SEL_MREQ, 64'h0);
        check_now();

        // Reset mid-execute
        execute_controlword = 33'h0_0000_0001;
        step();
        expect_v("pre_rst_state", SEL_STATE, 64'h1);
        check_now();
        reset = 1'b0;
        step();
        expect_v("mid_rst_instr", SEL_INSTR, 64'h0);
        expect_v("mid_rst_mreq", SEL_MREQ, 64'h1);
        expect_v("mid_rst_state", SEL_STATE, 64'h0);
        expect_v("mid_rst_status", SEL_STAT, 64'h0);
        expect_v("mid_rst_fault", SEL_FAULT, 64'h0);
        check_now();
        reset = 1'b1;
        step();
        expect_v("post_rst_cw", SEL_CW, 64'(CW_FETCH));
        check_now();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
